// File: rtl/apuf_pkg.sv
// Shared definitions for the arbiter-PUF response sampler: default
// geometry, a width helper and the per-channel packing offset.
package apuf_pkg;

  localparam int DEF_CHANNELS    = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_WORD_BITS   = 8;

  // Bits needed to count 0..value-1; never less than one bit.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'd1 << i) < 32'(value)) begin
        w = i + 1;
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

  // LSB position of channel c inside the packed output word.
  function automatic int chan_lsb(input int c, input int word_bits);
    return c * word_bits;
  endfunction

endpackage

// File: rtl/apuf_resp_sampler_if.sv
// Readout handshake between the response sampler (master) and the
// challenge/readout controller (slave).
interface apuf_resp_sampler_if
  import apuf_pkg::*;
#(
  parameter int CHANNELS  = DEF_CHANNELS,
  parameter int WORD_BITS = DEF_WORD_BITS
);

  logic [CHANNELS*WORD_BITS-1:0] out_data;
  logic                          out_valid;
  logic                          out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/apuf_sync.sv
// One-bit multi-flop synchroniser for a raw arbiter output. Only a
// plain shift chain: no filtering, so a change on d shows up on q
// after SYNC_STAGES rising edges.
module apuf_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_r;

  // Shift the asynchronous input through the synchroniser chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_r[SYNC_STAGES-1];

endmodule

// File: rtl/apuf_resp_sampler.sv
// Multi-channel arbiter-PUF response sampler: synchronises each arbiter
// output, packs WORD_BITS strobed samples per channel (LSB = first
// sample) and offers the finished word on a valid/ready handshake.
// Sampling never stalls; a word completing while an older one is still
// unread is dropped and flagged on the sticky overflow output.
module apuf_resp_sampler
  import apuf_pkg::*;
#(
  parameter int CHANNELS    = DEF_CHANNELS,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int WORD_BITS   = DEF_WORD_BITS
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [CHANNELS-1:0]          arb_in,
  input  logic                         sample_en,
  input  logic                         clear,
  apuf_resp_sampler_if.master          out_if,
  output logic                         overflow,
  output logic [clog2(WORD_BITS)-1:0]  sample_cnt
);

  localparam int CNT_W  = clog2(WORD_BITS);
  localparam int DATA_W = CHANNELS * WORD_BITS;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORD_BITS - 1);

  logic [CHANNELS-1:0] sync_q_s;

  logic [DATA_W-1:0]   acc_r;
  logic [DATA_W-1:0]   acc_ins_s;
  logic [DATA_W-1:0]   acc_nxt_s;
  logic [DATA_W-1:0]   data_r;
  logic [DATA_W-1:0]   data_nxt_s;
  logic [CNT_W-1:0]    cnt_r;
  logic [CNT_W-1:0]    cnt_nxt_s;
  logic                valid_r;
  logic                valid_nxt_s;
  logic                ovf_r;
  logic                ovf_nxt_s;
  logic                capture_s;
  logic                complete_s;
  logic                accept_s;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_sync
    apuf_sync #(
      .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (arb_in[c]),
      .q     (sync_q_s[c])
    );
  end

  // Accumulator with the current synchronised sample written at bit
  // position cnt_r of every channel slice.
  always_comb begin
    acc_ins_s = acc_r;
    for (int c = 0; c < CHANNELS; c++) begin
      acc_ins_s[chan_lsb(c, WORD_BITS) + int'(cnt_r)] = sync_q_s[c];
    end
  end

  // Capture, completion, handshake and overflow next-state decode.
  always_comb begin
    capture_s   = sample_en & ~clear;
    complete_s  = capture_s & (cnt_r == LAST_IDX);
    accept_s    = valid_r & out_if.out_ready;
    acc_nxt_s   = acc_r;
    cnt_nxt_s   = cnt_r;
    data_nxt_s  = data_r;
    valid_nxt_s = valid_r;
    ovf_nxt_s   = ovf_r;

    // clear beats a coincident strobe; the sample is simply lost
    if (clear) begin
      acc_nxt_s = {DATA_W{1'b0}};
      cnt_nxt_s = {CNT_W{1'b0}};
    end else if (complete_s) begin
      acc_nxt_s = {DATA_W{1'b0}};
      cnt_nxt_s = {CNT_W{1'b0}};
    end else if (capture_s) begin
      acc_nxt_s = acc_ins_s;
      cnt_nxt_s = cnt_r + CNT_W'(1);
    end else begin
      acc_nxt_s = acc_r;
      cnt_nxt_s = cnt_r;
    end

    // a completion may refill the slot in the same cycle it is read
    if (complete_s && (!valid_r || out_if.out_ready)) begin
      data_nxt_s  = acc_ins_s;
      valid_nxt_s = 1'b1;
    end else if (accept_s) begin
      valid_nxt_s = 1'b0;
    end else begin
      valid_nxt_s = valid_r;
    end

    if (clear) begin
      ovf_nxt_s = 1'b0;
    end else if (complete_s && valid_r && !out_if.out_ready) begin
      ovf_nxt_s = 1'b1;
    end else begin
      ovf_nxt_s = ovf_r;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r   <= {DATA_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      data_r  <= {DATA_W{1'b0}};
      valid_r <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      acc_r   <= acc_nxt_s;
      cnt_r   <= cnt_nxt_s;
      data_r  <= data_nxt_s;
      valid_r <= valid_nxt_s;
      ovf_r   <= ovf_nxt_s;
    end
  end

  assign out_if.out_data  = data_r;
  assign out_if.out_valid = valid_r;
  assign overflow         = ovf_r;
  assign sample_cnt       = cnt_r;

endmodule

// File: doc/apuf_resp_sampler.md
Name: apuf_resp_sampler

Overview:
Parametrised multi-channel successor to the single-bit response flop. It takes CHANNELS asynchronous arbiter outputs and passes each through a SYNC_STAGES-deep synchroniser. On each sample strobe it captures the synchronised bits and packs WORD_BITS consecutive responses per channel into one output word. The word is handed to the readout logic over a valid/ready handshake, with overflow detection. It sits between the arbiter PUF chains and the challenge/readout controller.

Parameters:
CHANNELS, 4, number of arbiter response inputs (1..32)
SYNC_STAGES, 2, synchroniser flops per channel (2..4)
WORD_BITS, 8, responses accumulated per channel per output word (2..64)

Ports:
clk  in  1  system clock; all flops rising-edge
rst_n  in  1  asynchronous active-low reset
arb_in  in  CHANNELS  raw arbiter outputs, asynchronous to clk
sample_en  in  1  single-cycle strobe, clk domain: capture synchronised responses this cycle
clear  in  1  synchronous flush of accumulator, counter and overflow
out_data  out  CHANNELS*WORD_BITS  packed word; channel c occupies bits [c*WORD_BITS +: WORD_BITS]
out_valid  out  1  out_data holds an unread word
out_ready  in  1  consumer accepts word when out_valid and out_ready are both 1
overflow  out  1  sticky: a completed word was lost
sample_cnt  out  clog2(WORD_BITS)  responses captured into the current word

Behaviour:
- Reset (rst_n=0, asynchronous): clears every synchroniser flop, the accumulator, sample_cnt, out_data, out_valid and overflow to 0. The reset is asynchronous. Words in flight are discarded and no partial word survives.
- Synchroniser: arb_in[c] reaches sync_q[c] after SYNC_STAGES clk edges. There is no other filtering. The controller holds the challenge stable for at least SYNC_STAGES+1 cycles before it strobes sample_en.
- Capture: on a cycle with sample_en=1 and clear=0, sync_q[c] is written into accumulator bit sample_cnt of channel c, LSB first, so bit k is the k-th sample. sample_cnt then increments.
- Word completion: when sample_en=1 and sample_cnt==WORD_BITS-1:
  - the full word, including this sample, is transferred to out_data;
  - out_valid=1 from the next cycle;
  - sample_cnt wraps to 0 and the accumulator clears.
- Handshake: out_data and out_valid hold steady while out_valid=1 and out_ready=0. On a cycle with out_valid=1 and out_ready=1, out_valid drops next cycle, unless a completion occurs in the same cycle (see below).
- Accumulation while full: sampling continues into the accumulator while an earlier word waits. Back-pressure never stalls sampling.
- Simultaneous completion and handshake:
  - If out_ready=1 on the completion cycle: the new word replaces out_data, out_valid stays 1, and overflow is unchanged.
  - If out_valid=1 and out_ready=0 on the completion cycle: the new word is dropped, out_data is kept, and overflow is set to 1 (sticky).
- clear=1: sample_cnt and the accumulator go to 0 and overflow goes to 0. out_data and out_valid are untouched, so a pending word can still be read. clear wins over a coincident sample_en, and that sample is discarded.
- sample_en pulse width: each cycle high counts as one sample. The controller is responsible for single-cycle strobes.
- Latency: the last sample_en cycle to out_valid=1 is 1 cycle. An arb_in edge to capture-eligible is SYNC_STAGES cycles.
- Widths: sample_cnt width is clog2(WORD_BITS), minimum 1. The wrap compares against WORD_BITS-1 explicitly, so non-power-of-2 WORD_BITS is legal.

Decomposition:
- apuf_pkg holds:
  - default values for CHANNELS, SYNC_STAGES and WORD_BITS;
  - a clog2 function;
  - the packing-offset helper chan_lsb(c, WORD_BITS) used by both RTL and bench.
- Sub-module apuf_sync: a one-bit, SYNC_STAGES-deep synchroniser with async active-low reset, instantiated CHANNELS times via generate. It is the direct generalisation of the existing single flop.

Test Plan:
- Reset mid-word: 3 samples taken, rst_n pulsed low for a partial cycle -> all outputs 0 immediately; next word starts at bit 0.
- Basic packing (CHANNELS=4, WORD_BITS=8): arb_in held at 4'b1010 for 8 strobes, out_ready=1 -> out_valid for 1 cycle. Each channel byte reads 8'hFF where its arb_in bit is 1 and 8'h00 where it is 0, so out_data=32'hFF00FF00 (channel 0 at bits 7:0).
- Bit order: channel 0 driven 1,0,0,0,0,0,0,1 across 8 strobes -> out_data[7:0]=8'h81.
- Synchroniser latency: arb_in[0] toggles 0->1, strobe at SYNC_STAGES-1 cycles after the toggle captures 0; strobe at SYNC_STAGES cycles after captures 1.
- Back-pressure/overflow:
  - out_ready=0, 16 strobes -> first word held, overflow=1 on the cycle after the 16th strobe, out_data still the first word.
  - clear -> overflow=0, out_valid still 1.
- Same-cycle completion with out_ready=1 while out_valid=1 -> out_data updates to the new word, out_valid stays 1, overflow stays 0. clear coincident with the 8th strobe -> no word produced, sample_cnt=0.
